// File: rtl/wallace_prod_accum_pkg.sv
// Shared types and default sizing for the Wallace product accumulator.
package wallace_prod_accum_pkg;

    localparam int unsigned DEF_M         = 8;
    localparam int unsigned DEF_ACC_W     = 12;
    localparam int unsigned DEF_MAX_TERMS = 16;
    localparam int unsigned DEF_CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/wallace_prod_accum_if.sv
// Product-in / result-out handshake bundle for the accumulator.
interface wallace_prod_accum_if #(
    parameter int unsigned M     = 8,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [M-1:0]     in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/wallace_prod_accum_adder.sv
// Accumulator adder: ACC_W-bit sum of running total and zero-extended product,
// with carry out. Build with ACC_SAT_EN defined to clamp the sum at all-ones
// on carry; otherwise the sum wraps.
module wallace_prod_accum_adder #(
    parameter int unsigned M     = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [M-1:0]     b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);
    logic [ACC_W:0] full_c;

    assign full_c = {1'b0, a} + (ACC_W+1)'(b);
    assign carry  = full_c[ACC_W];

`ifdef ACC_SAT_EN
    // Once clamped, any further nonzero product carries again, so the clamp holds.
    assign sum = carry ? {ACC_W{1'b1}} : full_c[ACC_W-1:0];
`else
    assign sum = full_c[ACC_W-1:0];
`endif

endmodule

// File: rtl/wallace_prod_accum.sv
// Multiply-accumulate back end: sums groups of multiplier product beats and
// presents sum, beat count and overflow on a held result handshake.
// Optional build macro: ACC_SAT_EN (saturating accumulator).
module wallace_prod_accum
    import wallace_prod_accum_pkg::*;
#(
    parameter int unsigned M         = DEF_M,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    wallace_prod_accum_if.slave  bus
);
    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ovf, ovf_n;
    logic             out_valid, out_valid_n;

    logic             accept_c;
    logic [ACC_W-1:0] add_base_c;
    logic [ACC_W-1:0] sum_c;
    logic             carry_c;
    logic [CNT_W-1:0] cnt_nxt_c;

    assign bus.in_ready = (state != HOLD);
    assign accept_c     = bus.in_valid && bus.in_ready;
    // First beat of a group starts from zero, so it never carries.
    assign add_base_c   = (state == IDLE) ? '0 : acc;
    assign cnt_nxt_c    = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);

    wallace_prod_accum_adder #(.M(M), .ACC_W(ACC_W)) u_adder (
        .a     (add_base_c),
        .b     (bus.in_prod),
        .sum   (sum_c),
        .carry (carry_c)
    );

    // Next-state, accumulator and result-valid logic.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        case (state)
            IDLE, ACCUM: begin
                if (accept_c) begin
                    acc_n   = sum_c;
                    cnt_n   = cnt_nxt_c;
                    ovf_n   = ((state == ACCUM) && ovf) || carry_c;
                    state_n = (bus.in_last || cnt_nxt_c == CNT_W'(MAX_TERMS)) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        out_valid_n = (state_n == HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            out_valid <= out_valid_n;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc;
    assign bus.out_cnt   = cnt;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_wallace_prod_accum.sv
// Directed bench for wallace_prod_accum: a 12-bit accumulator instance for the
// main scenarios and a 10-bit one for the overflow/saturation case.
module tb_wallace_prod_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    wallace_prod_accum_if #(.M(8), .ACC_W(12), .CNT_W(5)) b1 ();
    wallace_prod_accum_if #(.M(8), .ACC_W(10), .CNT_W(5)) b2 ();

    wallace_prod_accum #(.M(8), .ACC_W(12), .MAX_TERMS(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    wallace_prod_accum #(.M(8), .ACC_W(10), .MAX_TERMS(16), .CNT_W(5)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat1(input logic [7:0] p, input logic l);
        b1.in_valid = 1'b1;
        b1.in_prod  = p;
        b1.in_last  = l;
        chk("b1_ready", 32'(b1.in_ready), 32'd1);
        tick();
        b1.in_valid = 1'b0;
        b1.in_last  = 1'b0;
    endtask

    task automatic beat2(input logic [7:0] p, input logic l);
        b2.in_valid = 1'b1;
        b2.in_prod  = p;
        b2.in_last  = l;
        chk("b2_ready", 32'(b2.in_ready), 32'd1);
        tick();
        b2.in_valid = 1'b0;
        b2.in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b1.in_valid = 1'b0; b1.in_prod = '0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_prod = '0; b2.in_last = 1'b0; b2.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_acc",   32'(b1.out_acc),   32'd0);
        chk("rst_cnt",   32'(b1.out_cnt),   32'd0);
        chk("rst_ovf",   32'(b1.out_ovf),   32'd0);
        chk("rst_ready", 32'(b1.in_ready),  32'd1);

        // 1: reset mid-group discards the partial sum
        beat1(8'd9, 1'b0);
        beat1(8'd12, 1'b0);
        chk("t1_mid_valid", 32'(b1.out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t1_rst_valid", 32'(b1.out_valid), 32'd0);
        chk("t1_rst_cnt",   32'(b1.out_cnt),   32'd0);
        beat1(8'd3, 1'b1);
        chk("t1_valid", 32'(b1.out_valid), 32'd1);
        chk("t1_acc",   32'(b1.out_acc),   32'd3);
        chk("t1_cnt",   32'(b1.out_cnt),   32'd1);
        b1.out_ready = 1'b1;
        tick();
        chk("t1_drain", 32'(b1.out_valid), 32'd0);

        // 2: 15 + 14 + 16 with last on the third beat
        beat1(8'd15, 1'b0);
        beat1(8'd14, 1'b0);
        chk("t2_mid_valid", 32'(b1.out_valid), 32'd0);
        beat1(8'd16, 1'b1);
        chk("t2_valid", 32'(b1.out_valid), 32'd1);
        chk("t2_acc",   32'(b1.out_acc),   32'd45);
        chk("t2_cnt",   32'(b1.out_cnt),   32'd3);
        chk("t2_ovf",   32'(b1.out_ovf),   32'd0);
        chk("t2_ready", 32'(b1.in_ready),  32'd0);
        tick();
        chk("t2_drain", 32'(b1.out_valid), 32'd0);
        chk("t2_ready_back", 32'(b1.in_ready), 32'd1);

        // 3: sixteen beats of 225 force the group end; a 17th beat stalls
        b1.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) beat1(8'd225, 1'b0);
        chk("t3_valid", 32'(b1.out_valid), 32'd1);
        chk("t3_acc",   32'(b1.out_acc),   32'd3600);
        chk("t3_cnt",   32'(b1.out_cnt),   32'd16);
        chk("t3_ovf",   32'(b1.out_ovf),   32'd0);
        b1.in_valid = 1'b1;
        b1.in_prod  = 8'd225;
        chk("t3_stall_ready", 32'(b1.in_ready), 32'd0);
        tick();
        chk("t3_stall_cnt", 32'(b1.out_cnt), 32'd16);
        chk("t3_stall_acc", 32'(b1.out_acc), 32'd3600);
        b1.in_valid = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        chk("t3_drain", 32'(b1.out_valid), 32'd0);

        // 5: held result with a pending beat; accept only after drain
        b1.out_ready = 1'b0;
        beat1(8'd1, 1'b1);
        b1.in_valid = 1'b1;
        b1.in_prod  = 8'd7;
        b1.in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_ready", 32'(b1.in_ready),  32'd0);
            chk("t5_hold_valid", 32'(b1.out_valid), 32'd1);
            chk("t5_hold_acc",   32'(b1.out_acc),   32'd1);
            chk("t5_hold_cnt",   32'(b1.out_cnt),   32'd1);
            tick();
        end
        b1.out_ready = 1'b1;
        chk("t5_nobypass", 32'(b1.in_ready), 32'd0);
        tick();
        chk("t5_idle_valid", 32'(b1.out_valid), 32'd0);
        chk("t5_idle_ready", 32'(b1.in_ready),  32'd1);
        b1.out_ready = 1'b0;
        tick();
        b1.in_valid = 1'b0;
        b1.in_last  = 1'b0;
        chk("t5_acc_valid", 32'(b1.out_valid), 32'd1);
        chk("t5_acc",       32'(b1.out_acc),   32'd7);
        chk("t5_cnt",       32'(b1.out_cnt),   32'd1);
        b1.out_ready = 1'b1;
        tick();
        chk("t5_drain", 32'(b1.out_valid), 32'd0);

        // 6: gaps with in_last asserted but in_valid low add nothing
        b1.in_prod = 8'd50;
        b1.in_last = 1'b1;
        tick();
        tick();
        chk("t6_gap_valid", 32'(b1.out_valid), 32'd0);
        b1.in_last = 1'b0;
        beat1(8'd4, 1'b0);
        b1.in_prod = 8'd100;
        b1.in_last = 1'b1;
        tick();
        tick();
        chk("t6_gap2_valid", 32'(b1.out_valid), 32'd0);
        beat1(8'd5, 1'b1);
        chk("t6_pair_acc", 32'(b1.out_acc), 32'd9);
        chk("t6_pair_cnt", 32'(b1.out_cnt), 32'd2);
        tick();
        beat1(8'd9, 1'b1);
        chk("t6_valid", 32'(b1.out_valid), 32'd1);
        chk("t6_acc",   32'(b1.out_acc),   32'd9);
        chk("t6_cnt",   32'(b1.out_cnt),   32'd1);
        tick();
        chk("t6_drain", 32'(b1.out_valid), 32'd0);

        // 4: 10-bit accumulator, five beats of 225 (total 1125)
        b2.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat2(8'd225, 1'b0);
        beat2(8'd225, 1'b1);
        chk("t4_valid", 32'(b2.out_valid), 32'd1);
        chk("t4_cnt",   32'(b2.out_cnt),   32'd5);
        chk("t4_ovf",   32'(b2.out_ovf),   32'd1);
`ifdef ACC_SAT_EN
        chk("t4_acc",   32'(b2.out_acc),   32'd1023);
`else
        chk("t4_acc",   32'(b2.out_acc),   32'd101);
`endif
        b2.out_ready = 1'b1;
        tick();
        chk("t4_drain", 32'(b2.out_valid), 32'd0);
        beat2(8'd2, 1'b1);
        chk("t4_next_acc", 32'(b2.out_acc), 32'd2);
        chk("t4_next_ovf", 32'(b2.out_ovf), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
